// File: rtl/steer_en_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : steer_en_ctrl
//  Brief    : Rider-detect and steering-enable sequencer for balance_cntrl.
//             Registers left/right load-cell samples, decides rider presence
//             with hysteresis, and enables steering only after the rider has
//             stood evenly for a full settle-timer period.
//             Optional feature macro: RIDER_DEBOUNCE_EN (4-sample dismount
//             debounce on exits to IDLE).
//  Revision : 1.0 - initial release
// ============================================================================
module steer_en_ctrl #(
    parameter int          fast_sim      = 0,
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [11:0] WT_HYSTERESIS = 12'h040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int TMR_W = (fast_sim != 0) ? 15 : 26;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_STEER = 2'd2;

    localparam logic [12:0]      c_THR_HI  = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
    localparam logic [12:0]      c_THR_LO  = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};
    localparam logic [TMR_W-1:0] c_TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [11:0]      lft_q, lft_d;
    logic [11:0]      rght_q, rght_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic [12:0] w_sum;
    logic [11:0] w_diff;
    logic        w_sum_gt_min;
    logic        w_sum_lt_min;
    logic        w_diff_gt_1_4;
    logic        w_diff_gt_15_16;
    logic        w_tmr_full;
    logic        w_exit_low;

    // Sample capture: load on the strobe, otherwise hold.
    always_comb begin
        lft_d  = lft_q;
        rght_d = rght_q;
        if (ld_vld) begin
            lft_d  = lft_ld;
            rght_d = rght_ld;
        end
    end

    // Weight and balance decisions, all from the registered samples.
    always_comb begin
        w_sum           = {1'b0, lft_q} + {1'b0, rght_q};
        w_diff          = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
        w_sum_gt_min    = (w_sum > c_THR_HI);
        w_sum_lt_min    = (w_sum < c_THR_LO);
        w_diff_gt_1_4   = ({1'b0, w_diff} > (w_sum >> 2));
        w_diff_gt_15_16 = ({1'b0, w_diff} > (w_sum - (w_sum >> 4)));
        w_tmr_full      = &tmr_q;
    end

`ifdef RIDER_DEBOUNCE_EN
    // A dismount only counts after four consecutive low-weight samples.
    logic       vld_q;
    logic [1:0] dbnc_q, dbnc_d;

    // Debounce counter: steps once per fresh sample, cleared outside WAIT/STEER.
    always_comb begin
        dbnc_d     = dbnc_q;
        w_exit_low = vld_q && w_sum_lt_min && (dbnc_q == 2'd3);
        if ((state_q != c_WAIT && state_q != c_STEER) || w_exit_low) begin
            dbnc_d = 2'd0;
        end else if (vld_q) begin
            dbnc_d = w_sum_lt_min ? (dbnc_q + 2'd1) : 2'd0;
        end
    end

    // Debounce registers; vld_q marks the cycle a newly captured sample is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dbnc_q <= 2'd0;
        end else begin
            vld_q  <= ld_vld;
            dbnc_q <= dbnc_d;
        end
    end
`else
    assign w_exit_low = w_sum_lt_min;
`endif

    // Next-state and settle-timer logic; the timer only runs in WAIT.
    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        case (state_q)
            c_IDLE: begin
                if (w_sum_gt_min) begin
                    state_d = c_WAIT;
                end
            end
            c_WAIT: begin
                if (w_exit_low) begin
                    state_d = c_IDLE;
                end else if (w_diff_gt_1_4) begin
                    tmr_d = '0;
                end else if (w_tmr_full) begin
                    state_d = c_STEER;
                end else begin
                    tmr_d = tmr_q + c_TMR_ONE;
                end
            end
            c_STEER: begin
                if (w_exit_low) begin
                    state_d = c_IDLE;
                end else if (w_diff_gt_15_16) begin
                    state_d = c_WAIT;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // State, timer and sample registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            tmr_q   <= '0;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
        end
    end

    // Moore outputs decoded from the state register; unused codes read as no rider.
    always_comb begin
        en_steer  = (state_q == c_STEER);
        rider_off = (state_q != c_WAIT) && (state_q != c_STEER);
    end

endmodule
`default_nettype wire

// File: tb/tb_steer_en_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_steer_en_ctrl
//  Brief    : Scoreboard bench for steer_en_ctrl (fast_sim=1, 15-bit timer).
//             Output word encoding: {rider_off, en_steer}; IDLE=2, WAIT=0,
//             STEER=1. Dwell values are cycle counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_steer_en_ctrl;

    localparam int unsigned DWELL = 32768;
    localparam int unsigned LIMIT = 40000;
    localparam int unsigned O_IDLE  = 2;
    localparam int unsigned O_WAIT  = 0;
    localparam int unsigned O_STEER = 1;
`ifdef RIDER_DEBOUNCE_EN
    localparam int NLOW = 4;
`else
    localparam int NLOW = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        int unsigned val;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    steer_en_ctrl #(
        .fast_sim      (1),
        .MIN_RIDER_WT  (12'h200),
        .WT_HYSTERESIS (12'h040)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_vld    (ld_vld),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    function automatic int unsigned outs();
        return {30'd0, rider_off, en_steer};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input int unsigned v);
        exp_t x;
        x.name = n;
        x.val  = v;
        sb.push_back(x);
    endtask

    // One-cycle sample strobe; inputs scrambled afterwards to prove the hold.
    task automatic sample(input logic [11:0] l, input logic [11:0] r);
        ld_vld  = 1'b1;
        lft_ld  = l;
        rght_ld = r;
        tick();
        ld_vld  = 1'b0;
        lft_ld  = 12'($urandom);
        rght_ld = 12'($urandom);
    endtask

    // Cycles from now until en_steer rises (bounded).
    task automatic wait_steer(output int unsigned n, output bit ro_ok);
        n     = 0;
        ro_ok = 1'b1;
        while (en_steer !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
            if (rider_off !== 1'b0) ro_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_vld = 1'b1;
        lft_ld = 12'hFFF;
        rght_ld = 12'hFFF;
        push("reset", O_IDLE);
        tick();
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
        rst = 1'b0;
        ld_vld = 1'b0;
        push("reset_release", O_IDLE);
        tick();
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
    endtask

    task automatic test_idle_band();
        // sum 12'h240 equals the upper threshold: strict compare, no mount
        sample(12'h120, 12'h120);
        push("idle_band", O_IDLE);
        tick();
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
    endtask

    task automatic test_mount();
        int unsigned n;
        bit ro_ok;
        sample(12'h200, 12'h200);
        push("mount_latency", O_IDLE);
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
        push("mount", O_WAIT);
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
        push("mount_dwell", DWELL);
        push("mount_rider_on", 1);
        wait_steer(n, ro_ok);
        e = sb.pop_front(); total++;
        if (n !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
        e = sb.pop_front(); total++;
        if (32'(ro_ok) !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, ro_ok, e.val); end
    endtask

    task automatic test_steer_band();
        // sum 12'h1C0 equals the lower threshold: strict compare, stay in STEER
        sample(12'h0E0, 12'h0E0);
        push("steer_band", O_STEER);
        repeat (4) tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
    endtask

    task automatic test_step_off();
        sample(12'h3E0, 12'h010);
        push("step_off_latency", O_STEER);
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
        push("step_off", O_WAIT);
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
    endtask

    task automatic test_imbalance();
        int unsigned n;
        bit ro_ok;
        sample(12'h200, 12'h200);
        repeat (999) tick();
        sample(12'h300, 12'h100);
        push("imbalance_wait", O_WAIT);
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
        sample(12'h200, 12'h200);
        push("imbalance_dwell", DWELL);
        wait_steer(n, ro_ok);
        e = sb.pop_front(); total++;
        if (n !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, n, e.val); end
    endtask

    task automatic test_dismount();
`ifdef RIDER_DEBOUNCE_EN
        for (int i = 0; i < 3; i++) sample(12'h0D0, 12'h0D0);
        sample(12'h200, 12'h200);
        push("dbnc_three_low", O_STEER);
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
        for (int i = 0; i < 4; i++) sample(12'h0D0, 12'h0D0);
        push("dbnc_fourth_latency", O_STEER);
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
`else
        sample(12'h0D0, 12'h0D0);
        push("dismount_latency", O_STEER);
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
`endif
        push("dismount", O_IDLE);
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
    endtask

    task automatic test_priority();
        sample(12'h200, 12'h200);
        push("prio_mount", O_WAIT);
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
        // low sum and large imbalance together: the low sum must win
        for (int i = 0; i < NLOW; i++) sample(12'h1A0, 12'h000);
        push("prio_low_wins", O_IDLE);
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
    endtask

    task automatic test_reset_mid_wait();
        sample(12'h200, 12'h200);
        push("rst_mid_enter", O_WAIT);
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
        rst = 1'b1;
        push("rst_mid_wait", O_IDLE);
        tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
        rst = 1'b0;
        push("rst_mid_cleared", O_IDLE);
        repeat (3) tick();
        e = sb.pop_front(); total++;
        if (outs() !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, outs(), e.val); end
    endtask

    initial begin
        rst     = 1'b1;
        ld_vld  = 1'b0;
        lft_ld  = 12'h000;
        rght_ld = 12'h000;
        #1;
        test_reset();
        test_idle_band();
        test_mount();
        test_steer_band();
        test_step_off();
        test_imbalance();
        test_dismount();
        test_priority();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/steer_en_ctrl.md
Name: steer_en_ctrl

Overview:
- Rider-detect and steering-enable sequencer that drives the rider_off and en_steer inputs of balance_cntrl.
- Consumes left and right platform load-cell readings from the A2D interface. Decides whether a rider is aboard and whether the rider is balanced.
- Steering is enabled only after the rider has stood evenly for a settling period (about 1.34 s at 50 MHz).

Parameters:
- fast_sim, 0, 1 shrinks the settle timer to 15 bits for simulation; 0 uses 26 bits.
- MIN_RIDER_WT, 12'h200, nominal total-weight threshold for rider present.
- WT_HYSTERESIS, 12'h040, hysteresis applied around MIN_RIDER_WT.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ld_vld  input  1  one-cycle strobe; lft_ld/rght_ld are valid this cycle.
- lft_ld  input  12  unsigned left load-cell reading.
- rght_ld  input  12  unsigned right load-cell reading.
- en_steer  output  1  to balance_cntrl; 1 = steering input honoured.
- rider_off  output  1  to balance_cntrl; 1 = no rider (integrator cleared).

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, lft_q=rght_q=0, tmr=0, en_steer=0, rider_off=1. Reset overrides everything, including mid-WAIT and mid-STEER.
- Sample registers: lft_q/rght_q load on the edge where ld_vld=1 and hold otherwise. All decisions use lft_q/rght_q only.
- Arithmetic, combinational from registered samples:
  - sum = lft_q + rght_q, 13-bit, no overflow.
  - diff = |lft_q - rght_q|, 12-bit unsigned.
  - sum_gt_min = sum > MIN_RIDER_WT + WT_HYSTERESIS.
  - sum_lt_min = sum < MIN_RIDER_WT - WT_HYSTERESIS.
  - diff_gt_1_4 = diff > (sum>>2).
  - diff_gt_15_16 = diff > sum - (sum>>4). All compares strict.
- Settle timer:
  - Width is 26 bits (fast_sim=0) or 15 bits (fast_sim=1).
  - Increments every cycle in WAIT and is 0 in every other state.
  - tmr_full = all ones. The timer never wraps because the state leaves WAIT on tmr_full.
- FSM (Moore; outputs decode from the state register):
  - IDLE: rider_off=1, en_steer=0.
    - sum_gt_min -> WAIT, tmr cleared.
  - WAIT: rider_off=0, en_steer=0.
    - Priority 1: sum_lt_min -> IDLE.
    - Priority 2: diff_gt_1_4 -> stay, tmr cleared.
    - Priority 3: tmr_full -> STEER.
    - Otherwise stay, tmr+1.
  - STEER: rider_off=0, en_steer=1.
    - Priority 1: sum_lt_min -> IDLE.
    - Priority 2: diff_gt_15_16 -> WAIT, tmr cleared.
    - Otherwise stay.
- Sums between the two thresholds (hysteresis band) cause no IDLE entry or exit.
- Latency: ld_vld at edge N captures the samples. The state change is at edge N+1, and outputs change at edge N+1.
- WAIT dwell with balanced load is exactly 2^W cycles, where W is the timer width: the entry edge sets tmr=0, and the exit edge occurs with tmr=2^W-1.
- Simultaneous sum_lt_min and a diff condition: sum_lt_min wins.
- Unused state encoding: next state is IDLE.

Optional Feature:
- Macro RIDER_DEBOUNCE_EN.
- Defined:
  - Exit from WAIT or STEER to IDLE requires sum_lt_min on 4 consecutive ld_vld samples.
  - A 2-bit counter increments on each ld_vld sample with sum_lt_min and clears on any ld_vld sample without it.
  - Transition occurs on the edge after the 4th qualifying sample.
  - The counter resets on rst and on IDLE entry.
  - While debouncing, the other WAIT/STEER rules still apply (diff checks still clear tmr / drop to WAIT).
- Undefined: single-sample exit as in the FSM above, and no counter logic exists.

Test Plan:
- Reset: hold rst=1 for 2 cycles with arbitrary loads -> en_steer=0, rider_off=1, state IDLE.
- Balanced mount, fast_sim=1: ld_vld with lft=rght=12'h200 -> rider_off falls the next edge; en_steer rises exactly 32768 cycles later; rider_off stays 0.
- Imbalance restart in WAIT:
  - Mount with lft=rght=12'h200 (sum 12'h400); at tmr 1000, sample lft=12'h300, rght=12'h100 (diff 12'h200 > 12'h100) -> tmr resets to 0.
  - Restore balance -> en_steer rises 32768 cycles after the restore edge.
- Step-off in STEER: from STEER, sample lft=12'h3E0, rght=12'h010 (sum 12'h3F0, diff 12'h3D0 > 12'h3B1) -> en_steer=0 next edge, state WAIT, rider_off stays 0.
- Dismount and hysteresis:
  - From STEER, sample lft=rght=12'h0E0 (sum 12'h1C0, inside the 12'h1C0..12'h240 band) -> no change.
  - Sample lft=rght=12'h0D0 (sum 12'h1A0) -> rider_off=1, en_steer=0 next edge.
- RIDER_DEBOUNCE_EN: from STEER apply 3 low-sum samples then 1 balanced sample, then 4 low-sum samples -> no IDLE entry after the first three; IDLE on the edge after the 4th consecutive low-sum sample.
